// File: rtl/ue_tcam_pkg.sv
// Shared types, derived-geometry helpers and the ternary match function for the
// unit-element TCAM update engine.
package ue_tcam_pkg;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } upd_state_e;

    // Upper bound on subword width accepted by tern_hit; callers zero-extend.
    localparam int unsigned MaxSw = 32;

    function automatic int unsigned calc_sw_width(int unsigned width, int unsigned n);
        return width / n;
    endfunction

    function automatic int unsigned calc_sa_depth(int unsigned depth, int unsigned l);
        return depth / l;
    endfunction

    function automatic int unsigned calc_aw(int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned calc_bw(int unsigned depth, int unsigned l);
        return $clog2(depth / l);
    endfunction

    function automatic logic tern_hit(logic [MaxSw-1:0] idx, logic [MaxSw-1:0] patt_sw,
                                      logic [MaxSw-1:0] mask_sw);
        return ((idx ^ patt_sw) & ~mask_sw) == '0;
    endfunction

endpackage

// File: rtl/ue_tcam_updater.sv
// Expands one ternary entry (or a delete) into per-subword BRAM rows via a
// read-modify-write sweep over every subword value of the selected layer.
module ue_tcam_updater
    import ue_tcam_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 36,
    parameter int unsigned L     = 4,
    parameter int unsigned N     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_op,
    input  logic [$clog2(DEPTH)-1:0]     req_addr,
    input  logic [WIDTH-1:0]             req_patt,
    input  logic [WIDTH-1:0]             req_mask,
    output logic                         busy,
    output logic                         done,
    output logic [L-1:0]                 bram_wen,
    output logic [WIDTH/N-1:0]           bram_addr,
    output logic [N*(DEPTH/L)-1:0]       bram_din,
    input  logic [L*N*(DEPTH/L)-1:0]     bram_dout
);

    localparam int unsigned SW_WIDTH = calc_sw_width(WIDTH, N);
    localparam int unsigned SA_DEPTH = calc_sa_depth(DEPTH, L);
    localparam int unsigned AW       = calc_aw(DEPTH);
    localparam int unsigned BW       = calc_bw(DEPTH, L);
    localparam int unsigned LW       = AW - BW;

    upd_state_e            state_q, state_d;
    op_e                   op_q;
    logic [LW-1:0]         layer_q;
    logic [BW-1:0]         bit_q;
    logic [WIDTH-1:0]      patt_q;
    logic [WIDTH-1:0]      mask_q;
    logic [SW_WIDTH-1:0]   idx_q;
    logic                  last;

    logic [L-1:0][N-1:0][SA_DEPTH-1:0] dout_arr;
    logic [N-1:0][SA_DEPTH-1:0]        din_arr;
    logic [MaxSw-1:0]                  idx_ext, patt_ext, mask_ext;

    assign dout_arr = bram_dout;
    assign bram_din = din_arr;
    assign last     = (idx_q == {SW_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_INSERT;
            layer_q <= '0;
            bit_q   <= '0;
            patt_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                op_q    <= op_e'(req_op);
                layer_q <= req_addr[AW-1:BW];
                bit_q   <= req_addr[BW-1:0];
                patt_q  <= req_patt;
                mask_q  <= req_mask;
                idx_q   <= '0;
            end else if (state_q == StWrite && !last) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        bram_wen  = '0;
        bram_addr = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = StRead;
            end
            StRead: begin
                bram_addr = idx_q;
                state_d   = StWrite;
            end
            StWrite: begin
                bram_addr         = idx_q;
                bram_wen[layer_q] = 1'b1;
                state_d           = last ? StDone : StRead;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Insert rewrites the address bit on every row, which also erases any prior entry.
    always_comb begin
        din_arr  = dout_arr[layer_q];
        idx_ext  = '0;
        patt_ext = '0;
        mask_ext = '0;
        idx_ext[SW_WIDTH-1:0] = idx_q;
        for (int j = 0; j < N; j++) begin
            patt_ext[SW_WIDTH-1:0] = patt_q[j*SW_WIDTH +: SW_WIDTH];
            mask_ext[SW_WIDTH-1:0] = mask_q[j*SW_WIDTH +: SW_WIDTH];
            din_arr[j][bit_q] = (op_q == OP_INSERT) && tern_hit(idx_ext, patt_ext, mask_ext);
        end
    end

endmodule
